// File: rtl/multi_project_pkg.sv
// Shared definitions for the multi-project harness: project count,
// sequencer state encoding and Wishbone register addresses.
package multi_project_pkg;

   localparam int NUM_PROJECTS = 5;

   // state      | meaning
   // ST_BOOT    | unused after reset, falls back into a boot to project 0
   // ST_IDLE    | pads connected, active project out of reset, ready
   // ST_ISOLATE | pads isolated, every project forced into reset
   // ST_HOLD    | guard interval, mux select already switched to target
   // ST_RELEASE | target released, pads still isolated
   typedef enum logic [2:0] {
      ST_BOOT    = 3'd0,
      ST_IDLE    = 3'd1,
      ST_ISOLATE = 3'd2,
      ST_HOLD    = 3'd3,
      ST_RELEASE = 3'd4
   } seq_state_e;

   localparam logic [31:0] address_active = 32'h3000_0000;
   localparam logic [31:0] address_ws2812 = 32'h3000_0004;
   localparam logic [31:0] address_7seg   = 32'h3000_0008;
   localparam logic [31:0] address_freq   = 32'h3000_000C;

endpackage

// File: rtl/dwell_timer.sv
// Auto-rotate dwell counter: counts enabled cycles and pulses expire on the
// cycle where the count reaches dwell-1, then starts over.
module dwell_timer #(
   parameter int DWELL_W = 24
) (
   input  logic               clk,
   input  logic               reset_n,
   input  logic               clear,
   input  logic               enable,
   input  logic [DWELL_W-1:0] dwell,
   output logic               expire
);

   logic [DWELL_W-1:0] count_q;
   logic [DWELL_W-1:0] count_d;

   assign expire = enable && (count_q == (dwell - DWELL_W'(1)));

   // Next count: restart on clear, disable or expiry, otherwise increment.
   always_comb begin
      count_d = count_q;
      if (clear || !enable || expire) begin
         count_d = '0;
      end else begin
         count_d = count_q + DWELL_W'(1);
      end
   end

   // Counter register.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         count_q <= '0;
      end else begin
         count_q <= count_d;
      end
   end

endmodule

// File: rtl/project_switch_sequencer.sv
// Active-project switch sequencer: isolates the pads, holds the outgoing and
// incoming designs in reset for a guard interval, switches the mux select and
// releases only the incoming design. Reset lands in HOLD so that leaving
// reset boots project 0 along the normal path.
module project_switch_sequencer #(
   parameter int NUM_PROJECTS = multi_project_pkg::NUM_PROJECTS,
   parameter int GUARD_CYCLES = 4,
   parameter int DWELL_W      = 24
) (
   input  logic                    clk,
   input  logic                    reset_n,
   input  logic                    cfg_valid,
   output logic                    cfg_ready,
   input  logic [7:0]              cfg_project,
   input  logic                    auto_en,
   input  logic [DWELL_W-1:0]      dwell,
   output logic [7:0]              active_project,
   output logic                    io_isolate,
   output logic [NUM_PROJECTS-1:0] project_reset,
   output logic                    switch_done,
   output logic                    cfg_err
);

   import multi_project_pkg::*;

   localparam int GW = (GUARD_CYCLES > 1) ? $clog2(GUARD_CYCLES) : 1;
   localparam logic [GW-1:0] GUARD_LOAD = GW'(GUARD_CYCLES - 1);

   seq_state_e              state_q, state_d;
   logic [7:0]              target_q, target_d;
   logic [GW-1:0]           guard_q, guard_d;
   logic [7:0]              active_q, active_d;
   logic                    isolate_q, isolate_d;
   logic [NUM_PROJECTS-1:0] preset_q, preset_d;
   logic                    ready_q, ready_d;
   logic                    done_q, done_d;
   logic                    err_q, err_d;

   logic                    in_idle;
   logic                    ext_accept;
   logic                    auto_active;
   logic                    auto_expire;
   logic                    released;
   logic [7:0]              next_id;

   assign in_idle     = (state_q == ST_IDLE);
   assign ext_accept  = cfg_valid && ready_q;
   assign auto_active = auto_en && (dwell != '0);
   assign next_id     = (active_q >= 8'(NUM_PROJECTS - 1)) ? 8'd0 : active_q + 8'd1;

   // An external request in the same cycle wins over the auto step and
   // restarts the dwell count.
   dwell_timer #(.DWELL_W(DWELL_W)) u_dwell_timer (
      .clk     (clk),
      .reset_n (reset_n),
      .clear   (!in_idle || ext_accept),
      .enable  (in_idle && auto_active),
      .dwell   (dwell),
      .expire  (auto_expire)
   );

   // Next state and next values of all registered outputs.
   always_comb begin
      state_d  = state_q;
      target_d = target_q;
      guard_d  = guard_q;
      active_d = active_q;
      err_d    = 1'b0;
      done_d   = 1'b0;

      case (state_q)
         ST_IDLE: begin
            if (ext_accept) begin
               if (cfg_project < 8'(NUM_PROJECTS)) begin
                  target_d = cfg_project;
                  state_d  = ST_ISOLATE;
               end else begin
                  err_d = 1'b1;
               end
            end else if (auto_expire) begin
               target_d = next_id;
               state_d  = ST_ISOLATE;
            end
         end
         ST_ISOLATE: begin
            state_d  = ST_HOLD;
            guard_d  = GUARD_LOAD;
            active_d = target_q;
         end
         ST_HOLD: begin
            if (guard_q == '0) begin
               state_d = ST_RELEASE;
            end else begin
               guard_d = guard_q - GW'(1);
            end
         end
         ST_RELEASE: begin
            state_d = ST_IDLE;
            done_d  = 1'b1;
         end
         default: begin
            state_d  = ST_HOLD;
            target_d = 8'd0;
            guard_d  = GUARD_LOAD;
            active_d = 8'd0;
         end
      endcase

      released  = (state_d == ST_IDLE) || (state_d == ST_RELEASE);
      isolate_d = (state_d != ST_IDLE);
      ready_d   = (state_d == ST_IDLE);
      for (int i = 0; i < NUM_PROJECTS; i++) begin
         preset_d[i] = !(released && (active_d == 8'(i)));
      end
   end

   // State, counters and output registers.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state_q   <= ST_HOLD;
         target_q  <= 8'd0;
         guard_q   <= GUARD_LOAD;
         active_q  <= 8'd0;
         isolate_q <= 1'b1;
         preset_q  <= '1;
         ready_q   <= 1'b0;
         done_q    <= 1'b0;
         err_q     <= 1'b0;
      end else begin
         state_q   <= state_d;
         target_q  <= target_d;
         guard_q   <= guard_d;
         active_q  <= active_d;
         isolate_q <= isolate_d;
         preset_q  <= preset_d;
         ready_q   <= ready_d;
         done_q    <= done_d;
         err_q     <= err_d;
      end
   end

   assign cfg_ready      = ready_q;
   assign active_project = active_q;
   assign io_isolate     = isolate_q;
   assign project_reset  = preset_q;
   assign switch_done    = done_q;
   assign cfg_err        = err_q;

endmodule

// File: tb/tb_project_switch_sequencer.sv
// Directed bench for project_switch_sequencer (5 projects, guard 4).
module tb_project_switch_sequencer;

   logic        clk;
   logic        reset_n;
   logic        cfg_valid;
   logic        cfg_ready;
   logic [7:0]  cfg_project;
   logic        auto_en;
   logic [23:0] dwell;
   logic [7:0]  active_project;
   logic        io_isolate;
   logic [4:0]  project_reset;
   logic        switch_done;
   logic        cfg_err;

   int checks = 0;
   int errors = 0;

   project_switch_sequencer dut (
      .clk            (clk),
      .reset_n        (reset_n),
      .cfg_valid      (cfg_valid),
      .cfg_ready      (cfg_ready),
      .cfg_project    (cfg_project),
      .auto_en        (auto_en),
      .dwell          (dwell),
      .active_project (active_project),
      .io_isolate     (io_isolate),
      .project_reset  (project_reset),
      .switch_done    (switch_done),
      .cfg_err        (cfg_err)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   // Waits (bounded) for a switch_done sample; returns at that negedge.
   task automatic wait_done(input string tag);
      logic seen;
      seen = 1'b0;
      for (int i = 0; i < 20 && !seen; i++) begin
         @(negedge clk);
         seen = switch_done;
      end
      chk(tag, 32'(seen), 32'd1);
   endtask

   initial begin
      reset_n     = 1'b0;
      cfg_valid   = 1'b0;
      cfg_project = 8'd0;
      auto_en     = 1'b0;
      dwell       = 24'd0;

      // Reset values
      @(negedge clk);
      @(negedge clk);
      chk("rst_active",  32'(active_project), 32'd0);
      chk("rst_isolate", 32'(io_isolate),     32'd1);
      chk("rst_preset",  32'(project_reset),  32'h1F);
      chk("rst_ready",   32'(cfg_ready),      32'd0);
      chk("rst_done",    32'(switch_done),    32'd0);
      chk("rst_err",     32'(cfg_err),        32'd0);

      // Boot to project 0: pads isolated until done
      reset_n = 1'b1;
      begin
         logic seen;
         seen = 1'b0;
         for (int i = 0; i < 12 && !seen; i++) begin
            @(negedge clk);
            if (switch_done) seen = 1'b1;
            else chk("boot_isolate", 32'(io_isolate), 32'd1);
         end
         chk("boot_done", 32'(seen), 32'd1);
      end
      chk("boot_active",  32'(active_project), 32'd0);
      chk("boot_preset",  32'(project_reset),  32'h1E);
      chk("boot_isolate_low", 32'(io_isolate), 32'd0);
      chk("boot_ready",   32'(cfg_ready),      32'd1);

      // Valid switch to 3; a different request held mid-switch is ignored
      @(negedge clk);
      cfg_valid = 1'b1; cfg_project = 8'd3;
      @(negedge clk);                                    // c1
      chk("c1_isolate", 32'(io_isolate),     32'd1);
      chk("c1_preset",  32'(project_reset),  32'h1F);
      chk("c1_ready",   32'(cfg_ready),      32'd0);
      chk("c1_active",  32'(active_project), 32'd0);
      cfg_project = 8'd1;
      @(negedge clk);                                    // c2
      chk("c2_active",  32'(active_project), 32'd3);
      chk("c2_preset",  32'(project_reset),  32'h1F);
      for (int c = 3; c <= 5; c++) begin
         @(negedge clk);
         chk("hold_isolate", 32'(io_isolate),    32'd1);
         chk("hold_preset",  32'(project_reset), 32'h1F);
      end
      cfg_valid = 1'b0;
      @(negedge clk);                                    // c6 RELEASE
      chk("c6_preset",  32'(project_reset), 32'h17);
      chk("c6_isolate", 32'(io_isolate),    32'd1);
      chk("c6_done",    32'(switch_done),   32'd0);
      @(negedge clk);                                    // c7 IDLE
      chk("c7_done",    32'(switch_done),    32'd1);
      chk("c7_isolate", 32'(io_isolate),     32'd0);
      chk("c7_ready",   32'(cfg_ready),      32'd1);
      chk("c7_active",  32'(active_project), 32'd3);
      chk("c7_preset",  32'(project_reset),  32'h17);
      @(negedge clk);
      chk("c8_done",    32'(switch_done),    32'd0);

      // Invalid id 5
      cfg_valid = 1'b1; cfg_project = 8'd5;
      @(negedge clk);
      cfg_valid = 1'b0;
      chk("inv_err",     32'(cfg_err),        32'd1);
      chk("inv_ready",   32'(cfg_ready),      32'd1);
      chk("inv_active",  32'(active_project), 32'd3);
      chk("inv_isolate", 32'(io_isolate),     32'd0);
      chk("inv_preset",  32'(project_reset),  32'h17);
      @(negedge clk);
      chk("inv_err_pulse", 32'(cfg_err),    32'd0);
      chk("inv_stay",      32'(io_isolate), 32'd0);

      // dwell=0 keeps auto-rotate off
      auto_en = 1'b1; dwell = 24'd0;
      repeat (15) @(negedge clk);
      chk("dwell0_idle", 32'(io_isolate), 32'd0);

      // Switch to 4 with auto-rotate armed (dwell 10)
      cfg_valid = 1'b1; cfg_project = 8'd4; dwell = 24'd10;
      @(negedge clk);
      cfg_valid = 1'b0;
      wait_done("to4_done");
      chk("to4_active", 32'(active_project), 32'd4);
      for (int i = 1; i <= 9; i++) begin
         @(negedge clk);
         chk("auto_wait", 32'(io_isolate), 32'd0);
      end
      @(negedge clk);
      chk("auto_fire", 32'(io_isolate), 32'd1);
      wait_done("auto_done");
      chk("auto_wrap",   32'(active_project), 32'd0);
      chk("auto_preset", 32'(project_reset),  32'h1E);

      // Collision: external id 2 on the dwell-expiry cycle
      for (int i = 1; i <= 9; i++) begin
         @(negedge clk);
         chk("col_wait", 32'(io_isolate), 32'd0);
      end
      cfg_valid = 1'b1; cfg_project = 8'd2;
      @(negedge clk);
      cfg_valid = 1'b0;
      chk("col_isolate", 32'(io_isolate), 32'd1);
      wait_done("col_done");
      chk("col_active", 32'(active_project), 32'd2);
      for (int i = 1; i <= 9; i++) begin
         @(negedge clk);
         chk("col_restart", 32'(io_isolate), 32'd0);
      end
      @(negedge clk);
      chk("col_refire", 32'(io_isolate), 32'd1);
      auto_en = 1'b0;
      wait_done("col2_done");
      chk("col2_active", 32'(active_project), 32'd3);
      repeat (12) @(negedge clk);
      chk("auto_off", 32'(io_isolate), 32'd0);

      // Reset mid-HOLD of a switch to 1
      cfg_valid = 1'b1; cfg_project = 8'd1;
      @(negedge clk);                                    // c1
      cfg_valid = 1'b0;
      @(negedge clk);                                    // c2
      chk("mid_c2_active", 32'(active_project), 32'd1);
      @(negedge clk);                                    // c3
      reset_n = 1'b0;
      #1;
      chk("mid_rst_active",  32'(active_project), 32'd0);
      chk("mid_rst_preset",  32'(project_reset),  32'h1F);
      chk("mid_rst_isolate", 32'(io_isolate),     32'd1);
      chk("mid_rst_ready",   32'(cfg_ready),      32'd0);
      @(negedge clk);
      reset_n = 1'b1;
      wait_done("reboot_done");
      chk("reboot_active",  32'(active_project), 32'd0);
      chk("reboot_preset",  32'(project_reset),  32'h1E);
      chk("reboot_isolate", 32'(io_isolate),     32'd0);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
